// File: rtl/alu_serial_ctrl.sv
// Bit-serial initiator for a shared 1-bit ALU slice: streams operand bits LSB first
// and collects the slice's sum bits into a WIDTH-bit result with a zero flag.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [5:0]       slice_signal,
  input  logic             slice_out,
  input  logic             slice_cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_SLT = 6'b101010;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_reg, b_reg, res, fin;
  logic [5:0]       op_reg;
  logic             accept, last, sub_like;

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign last     = (cnt == CW'(WIDTH - 1));
  assign sub_like = (op_reg == OP_SUB) || (op_reg == OP_SLT);

  assign slice_a      = busy & a_reg[cnt];
  assign slice_b      = busy & b_reg[cnt];
  assign slice_cin    = busy & ((cnt == '0) ? sub_like : carry);
  assign slice_signal = op_reg;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        accept    = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SLT: sign of the difference corrected for signed overflow (cin_msb ^ cout_msb)
  always_comb begin
    fin             = res;
    fin[WIDTH-1]    = slice_out;
    if (op_reg == OP_SLT)
      fin = {{(WIDTH-1){1'b0}}, slice_out ^ carry ^ slice_cout};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
      res    <= '0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg  <= a;
        b_reg  <= b;
        op_reg <= op;
        cnt    <= '0;
        res    <= '0;
        carry  <= 1'b0;
      end else if (busy) begin
        res[cnt] <= slice_out;
        carry    <= slice_cout;
        cnt      <= cnt + CW'(1);
        if (last) begin
          result <= fin;
          zero   <= (fin == '0);
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench: behavioural 1-bit slice, scoreboard of expected results
// pushed on each accepted start and popped on each done pulse.
module tb_alu_serial_ctrl;
  localparam int W = 32;
  localparam logic [5:0] OP_AND = 6'b100100, OP_OR = 6'b100101, OP_ADD = 6'b100000,
                         OP_SUB = 6'b100010, OP_SLT = 6'b101010, OP_BAD = 6'b000000;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [5:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero;
  logic [W-1:0] result;
  logic         slice_a, slice_b, slice_cin, slice_out, slice_cout;
  logic [5:0]   slice_signal;

  int checks = 0, failures = 0;
  logic [W-1:0] expq[$];
  logic [W-1:0] last_exp = '0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_signal(slice_signal), .slice_out(slice_out), .slice_cout(slice_cout)
  );

  always #5 clk = ~clk;

  // Slice model: AND/OR bitwise, ADD a+b+cin, SUB/SLT a+~b+cin, else 0
  logic sb;
  always_comb begin
    sb         = slice_b;
    slice_out  = 1'b0;
    slice_cout = 1'b0;
    case (slice_signal)
      OP_AND: slice_out = slice_a & slice_b;
      OP_OR:  slice_out = slice_a | slice_b;
      OP_ADD, OP_SUB, OP_SLT: begin
        if (slice_signal != OP_ADD) sb = ~slice_b;
        slice_out  = slice_a ^ sb ^ slice_cin;
        slice_cout = (slice_a & sb) | (slice_a & slice_cin) | (sb & slice_cin);
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [5:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_SLT:  return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) expq.delete();
    else if (start && !busy) expq.push_back(model(op, a, b));
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (done) begin
      if (expq.size() == 0) check("spurious_done", W'(1), W'(0));
      else begin
        e = expq.pop_front();
        check("result", result, e);
        check("zero", W'(zero), W'(e == '0));
        last_exp = e;
      end
    end
  end

  task automatic wait_done(output int nbusy);
    nbusy = 0;
    for (int k = 0; k < 100; k++) begin
      if (done) return;
      if (busy) nbusy++;
      @(negedge clk);
    end
    check("timeout", W'(0), W'(1));
  endtask

  task automatic run_op(input logic [5:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic cin0);
    logic [W-1:0] prev;
    int nb;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    prev = last_exp;
    @(negedge clk);
    start = 1'b0;
    check("cin_bit0", W'(slice_cin), W'(cin0));
    check("held_in_run", result, prev);
    wait_done(nb);
    check("busy_cycles", W'(nb), W'(32));
    @(negedge clk);
    check("done_one_cycle", W'(done), W'(0));
    check("sig_hold", W'(slice_signal), W'(o));
    check("idle_slice", W'({slice_a, slice_b, slice_cin}), W'(0));
  endtask

  initial begin
    int n1, n2;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_result", result, W'(0));
    check("rst_zero", W'(zero), W'(1));
    check("rst_sig", W'(slice_signal), W'(0));
    check("rst_slice", W'({slice_a, slice_b, slice_cin}), W'(0));
    reset = 1'b1;

    run_op(OP_ADD, 32'd5, 32'd7, 1'b0);
    check("add_const", result, 32'h0000000C);
    run_op(OP_SUB, 32'd3, 32'd5, 1'b1);
    check("sub_const", result, 32'hFFFFFFFE);
    run_op(OP_SUB, 32'h1234, 32'h1234, 1'b1);
    run_op(OP_SLT, 32'hFFFFFFFF, 32'd1, 1'b1);
    check("slt_neg", result, 32'd1);
    run_op(OP_SLT, 32'h7FFFFFFF, 32'h80000000, 1'b1);
    check("slt_ovf", result, 32'd0);
    run_op(OP_SLT, 32'h80000000, 32'h7FFFFFFF, 1'b1);
    check("slt_min", result, 32'd1);
    run_op(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    check("and_const", result, 32'hF000F000);
    run_op(OP_OR, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    check("or_const", result, 32'hFFF0FFF0);
    run_op(OP_BAD, 32'hDEADBEEF, 32'h12345678, 1'b0);
    check("bad_zero", W'(zero), W'(1));

    // start held high with operands changing every cycle
    @(negedge clk);
    op = OP_ADD; a = 32'd1; b = 32'd2; start = 1'b1;
    n1 = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); n1++;
      if (done) break;
      a = $urandom; b = $urandom;
    end
    check("b2b_first", W'(n1), W'(33));
    n2 = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); n2++;
      if (done) break;
      a = $urandom; b = $urandom;
    end
    check("b2b_period", W'(n2), W'(33));
    start = 1'b0;
    @(negedge clk);
    check("b2b_idle", W'(busy), W'(0));

    // reset in the middle of a RUN
    op = OP_ADD; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", W'(busy), W'(1));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    last_exp = '0;
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_done", W'(done), W'(0));
    check("mid_rst_result", result, W'(0));
    check("mid_rst_zero", W'(zero), W'(1));
    repeat (40) @(negedge clk);
    run_op(OP_ADD, 32'hFFFFFFFF, 32'd1, 1'b0);
    check("wrap_zero", W'(zero), W'(1));
    check("queue_empty", W'(expq.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
Bit-serial initiator for the 1-bit ALU slice (AND/OR/ADD/SUB/SLT funct codes). It accepts a full-width operation and drives the slice's dataA/dataB/dataC/Signal inputs one bit per cycle, LSB first. It collects the slice's dataOut/cout into a WIDTH-bit result with a zero flag. It sits between EX-stage issue logic and a single shared ALU slice, and trades latency for area.

Parameters:
WIDTH, 32, operand/result width in bits; also the number of RUN cycles per operation.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (reset==0 at a clk edge resets the block)
start  input  1  request; accepted only when busy==0
op  input  6  funct code: AND=100100, OR=100101, ADD=100000, SUB=100010, SLT=101010; others are "unsupported"
a  input  WIDTH  operand A, sampled on accepted start
b  input  WIDTH  operand B, sampled on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result is valid
result  output  WIDTH  final result; held until the next accepted start
zero  output  1  result==0; valid when done, held with result
slice_a  output  1  to slice dataA
slice_b  output  1  to slice dataB
slice_cin  output  1  to slice dataC (carry in)
slice_signal  output  6  to slice Signal
slice_out  input  1  from slice dataOut
slice_cout  input  1  from slice cout

Behaviour:
- Slice contract (fixed): combinational, same-cycle response. For SUB and SLT it computes A + ~B + cin internally. For unsupported codes dataOut is 0.
- Reset values: state=IDLE, busy=0, done=0, result=0, zero=1, slice_signal=0, slice_a/b/cin=0, counter=0, carry register=0.
- FSM states and transitions:
  - IDLE: start -> RUN.
  - RUN: stays in RUN until counter==WIDTH-1, then -> DONE.
  - DONE: lasts exactly one cycle, done=1. Goes to RUN if start is high, else IDLE.
- start is accepted in IDLE or DONE (busy==0). On acceptance: latch a, b, op; clear counter and the result shift register.
- start during RUN is ignored. Operands are not re-sampled.
- During RUN (counter=i):
  - slice_a = a_reg[i], slice_b = b_reg[i].
  - slice_cin: at i==0, 1 for SUB/SLT and 0 otherwise; at i>0, the carry register.
  - slice_signal = op_reg.
  - At the clk edge: res[i] <= slice_out; carry <= slice_cout; counter++.
- SLT final cycle (i==WIDTH-1):
  - overflow = carry_reg ^ slice_cout.
  - result <= {WIDTH-1 zeros, slice_out ^ overflow}.
  - This is a signed compare.
- AND/OR/ADD/SUB/unsupported: result = assembled bits. Unsupported codes give 0. Carry-out is discarded; ADD/SUB wrap modulo 2^WIDTH.
- Outside RUN: slice_a/b/cin = 0; slice_signal holds the last op_reg.
- Latency: start sampled at edge 0 -> busy=1 for cycles 1..WIDTH -> done=1 in cycle WIDTH+1. Back-to-back start in DONE gives a throughput of one op per WIDTH+1 cycles.
- result/zero update only at the transition into DONE. They are stable at all other times, including through a later RUN, until the next DONE.
- Reset has priority over everything, including mid-RUN: the next cycle is IDLE with reset values. No done pulse is issued for the aborted op.

Test Plan:
- ADD, a=5, b=7, start at cycle 0 -> busy cycles 1..32; done=1 only in cycle 33; result=0x0000000C; zero=0.
- SUB, a=3, b=5 -> result=0xFFFFFFFE. SUB, a=b=0x1234 -> result=0, zero=1.
- SLT cases:
  - a=0xFFFFFFFF, b=1 -> result=1.
  - a=0x7FFFFFFF, b=0x80000000 -> result=0 (overflow path).
  - a=0x80000000, b=0x7FFFFFFF -> result=1.
- AND and OR, a=0xF0F0F0F0, b=0xFF00FF00 -> AND gives 0xF000F000; OR gives 0xFFF0FFF0. Also check slice_cin=0 on bit 0. Unsupported op 000000 -> result=0, zero=1.
- start held high through an entire RUN with changing a/b -> only the first op completes with the latched operands; a new op starts from DONE; done pulses every 33 cycles.
- reset=0 at RUN cycle 10 -> next cycle: busy=0, result=0, zero=1, no done pulse; a fresh start afterwards completes normally.
